std_packet_fifo: RTL and testbench
==================================

# std_packet_fifo

Packet-aware successor to the plain synchronous FIFO. Words are written speculatively and become visible to the reader only when the packet's last word is committed. A packet can be dropped mid-write, and one that overflows is discarded automatically. It sits between packet sources (bus bridges, protocol parsers) and consumers that must never see partial or aborted packets.

## Interface
- WIDTH, 8, payload bit width
- TYPE, logic [WIDTH-1:0], payload type
- DEPTH, 16, word capacity; must be ≥ 2
- MAX_PACKETS, DEPTH, maximum number of committed packets held
- THRESHOLD, DEPTH - 1, almost-full level in words; must satisfy 1 ≤ THRESHOLD ≤ DEPTH
- i_clk  input  1  clock; all state changes on its rising edge
- i_rst  input  1  reset, asynchronous, active-low
- i_clear  input  1  synchronous clear of all pointers, counts and the packet in progress
- i_push  input  1  write request
- i_data  input  TYPE  write word
- i_last  input  1  the current push is the final word of its packet
- i_drop  input  1  abort the packet currently being written
- o_full  output  1  no free word slot, or MAX_PACKETS packets are committed
- o_almost_full  output  1  words in use, counted against the write-side pointer, are ≥ THRESHOLD
- o_overflow  output  1  one-cycle pulse when an overflowed packet is discarded
- i_pop  input  1  read request
- o_empty  output  1  no committed packet
- o_data  output  TYPE  word at the read pointer; valid while !o_empty
- o_last  output  1  o_data is the last word of its packet
- o_word_count  output  $clog2(DEPTH+1)  committed, unread words
- o_packet_count  output  $clog2(MAX_PACKETS+1)  committed packets not fully read

## Operation
- Pointers:
  - wr_ptr: tentative write pointer.
  - cmt_ptr: last committed write position.
  - rd_ptr: read pointer.
  - All wrap modulo DEPTH. Each pointer carries an extra wrap bit for the full/empty distinction.
- Free space = DEPTH − (wr_ptr − rd_ptr). A push is accepted only when !o_full.
- Accepted push: {i_data, i_last} is stored at wr_ptr and wr_ptr advances.
  - If i_last is set: cmt_ptr ← wr_ptr + 1 and the packet count increments.
- i_drop (with or without i_push): wr_ptr ← cmt_ptr. The in-progress word is not stored. i_drop takes priority over i_last in the same cycle.
- Overflow: i_push while o_full and a packet is in progress sets the internal bad flag.
  - While bad, pushes are ignored.
  - On the push carrying i_last, or on i_drop: wr_ptr ← cmt_ptr, bad clears and o_overflow pulses. The pulse happens for the i_last case; i_drop clears bad without a pulse.
  - A push while o_full with no packet in progress is silently ignored.
- Pop: i_pop with !o_empty advances rd_ptr.
  - A pop of a word with o_last set decrements the packet count.
  - i_pop while empty is ignored.
- Reader visibility: the reader sees only words in [rd_ptr, cmt_ptr). o_data and o_last are combinational reads of storage at rd_ptr (first-word fall-through).
- i_clear: all pointers, counts and the bad flag return to their reset values. A packet in progress is lost. Storage contents are not cleared.

## Timing
- Reset and clear values:
  - o_empty = 1; o_full = 0; o_almost_full = 0; o_overflow = 0.
  - Both counts = 0; o_data = TYPE'(0); o_last = 0.
- Commit latency: a packet whose last word is pushed in cycle N shows !o_empty and updated counts in cycle N+1.
- Flags and counts (o_full, o_almost_full, o_empty, both counts) are registered and reflect the state after the previous edge.
- Simultaneous push and pop when o_full: the push is rejected. Freed space becomes usable the cycle after the pop.
- Simultaneous commit and pop of the final committed word:
  - Net packet count is unchanged.
  - o_empty stays 0 if the newly committed packet exists.
- Single-word packet: i_push with i_last in the same cycle is a legal packet.
- Reset asserted mid-packet: all state returns to reset values immediately (asynchronous).

## Structure
- Shared package std_packet_fifo_pkg holds:
  - pointer type: logic [$clog2(DEPTH):0];
  - count types;
  - function ptr_distance(a, b), which returns a − b with wrap handling.
- Sub-module std_packet_fifo_ctrl holds the pointers, bad flag, counters and flags. The top level holds the storage array of {TYPE, last} and the output muxing.

## Test plan
- Reset, then push a 3-word packet 0xA1, 0xA2, 0xA3 (last on 0xA3):
  - o_empty stays 1 until the cycle after 0xA3, then o_word_count = 3 and o_packet_count = 1;
  - pops return A1, A2, A3 with o_last only on A3.
- Push 2 words, then assert i_drop → o_empty remains 1 and o_full = 0. A following 1-word packet 0x55 pops correctly.
- DEPTH = 4: push a 6-word packet → o_full after 4 words. On the last word, o_overflow pulses once, o_empty = 1 and o_word_count = 0.
- Wrap: with DEPTH = 4, push and pop 5 one-word packets 0x01–0x05 interleaved → read order is preserved; o_last = 1 each time.
- MAX_PACKETS = 2, DEPTH = 8: commit 2 one-word packets → o_full = 1 despite free words. Pop one → o_full = 0 in the next cycle.
- Assert i_clear mid-packet with 2 packets committed → the next cycle shows reset values on all outputs except storage.

Source files
------------

// File: rtl/std_packet_fifo_pkg.sv
// -----------------------------------------------------------------------------
// std_packet_fifo_pkg
//
// Shared types and helpers for the packet FIFO.
//
// Pointers are laid out as {wrap, index}. The index counts modulo DEPTH, and
// DEPTH need not be a power of two. The helpers take the index width and the
// depth as arguments, so a single package serves every instance. Pointer
// values are passed in a 32-bit container, and callers cast back to their own
// pointer width.
// -----------------------------------------------------------------------------
package std_packet_fifo_pkg;

    // Wide container for pointers of any instance width.
    typedef logic [31:0] ptr_max_t;
    // Wide container for word distances / counts before sizing to a port.
    typedef logic [31:0] cnt_max_t;

    // Write-side state: accepting words, or discarding an overflowed packet.
    typedef enum logic {
        WR_OK  = 1'b0,
        WR_BAD = 1'b1
    } wr_state_t;

    function automatic ptr_max_t ptr_index(input ptr_max_t p, input int unsigned idx_w);
        return p & ((ptr_max_t'(1) << idx_w) - ptr_max_t'(1));
    endfunction

    function automatic logic ptr_wrap(input ptr_max_t p, input int unsigned idx_w);
        ptr_max_t shifted;
        shifted = p >> idx_w;
        return shifted[0];
    endfunction

    // Advance a pointer by one slot. Past DEPTH-1, the index returns to 0 and
    // the wrap bit toggles.
    function automatic ptr_max_t ptr_next(input ptr_max_t p, input int unsigned idx_w,
                                          input int unsigned depth);
        ptr_max_t idx;
        logic     wrap;
        idx  = ptr_index(p, idx_w);
        wrap = ptr_wrap(p, idx_w);
        if (idx == ptr_max_t'(depth - 1)) begin
            idx  = '0;
            wrap = ~wrap;
        end else begin
            idx = idx + ptr_max_t'(1);
        end
        return (ptr_max_t'(wrap) << idx_w) | idx;
    endfunction

    // Return a - b in words, where a is at or ahead of b. When the wrap bits
    // differ, a has wrapped past the end of storage once more than b has.
    function automatic cnt_max_t ptr_distance(input ptr_max_t a, input ptr_max_t b,
                                              input int unsigned idx_w,
                                              input int unsigned depth);
        if (ptr_wrap(a, idx_w) == ptr_wrap(b, idx_w))
            return ptr_index(a, idx_w) - ptr_index(b, idx_w);
        else
            return cnt_max_t'(depth) + ptr_index(a, idx_w) - ptr_index(b, idx_w);
    endfunction

endpackage

// File: rtl/std_packet_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// std_packet_fifo_ctrl
//
// Pointer, packet-count and flag control for std_packet_fifo.
//
// Ports:
//   i_clk, i_rst      clock; asynchronous active-low reset
//   i_clear           synchronous clear of all pointers, counts and bad state
//   i_push, i_last    write request / last word of packet
//   i_drop            abort the packet being written
//   i_pop             read request
//   i_rd_last         'last' bit stored at the read pointer
//   o_wr_en, o_wr_idx storage write strobe and slot
//   o_rd_idx          storage read slot
//   o_full, o_almost_full, o_empty, o_overflow   registered status
//   o_word_count, o_packet_count                 registered counts
// -----------------------------------------------------------------------------
module std_packet_fifo_ctrl
    import std_packet_fifo_pkg::*;
#(
    parameter  int unsigned DEPTH       = 16,
    parameter  int unsigned MAX_PACKETS = DEPTH,
    parameter  int unsigned THRESHOLD   = DEPTH - 1,
    localparam int unsigned IDX_W       = $clog2(DEPTH),
    localparam int unsigned WC_W        = $clog2(DEPTH + 1),
    localparam int unsigned PC_W        = $clog2(MAX_PACKETS + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic             i_last,
    input  logic             i_drop,
    input  logic             i_pop,
    input  logic             i_rd_last,
    output logic             o_wr_en,
    output logic [IDX_W-1:0] o_wr_idx,
    output logic [IDX_W-1:0] o_rd_idx,
    output logic             o_full,
    output logic             o_almost_full,
    output logic             o_overflow,
    output logic             o_empty,
    output logic [WC_W-1:0]  o_word_count,
    output logic [PC_W-1:0]  o_packet_count
);

    localparam int unsigned PTR_W = IDX_W + 1;
    typedef logic [PTR_W-1:0] ptr_t;

    ptr_t            wr_ptr, cmt_ptr, rd_ptr;
    ptr_t            wr_ptr_nxt, cmt_ptr_nxt, rd_ptr_nxt;
    wr_state_t       state, state_nxt;
    logic [PC_W-1:0] pkt_cnt, pkt_cnt_nxt;
    logic            overflow_nxt;
    logic            wr_en;
    logic            push_ok, pop_ok, in_progress;
    logic            commit, release_pkt;
    cnt_max_t        used_nxt, words_nxt;

    function automatic ptr_t inc(input ptr_t p);
        return ptr_t'(ptr_next(ptr_max_t'(p), IDX_W, DEPTH));
    endfunction

    // NOTE: every signal driven here gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_nxt   = wr_ptr;
        cmt_ptr_nxt  = cmt_ptr;
        rd_ptr_nxt   = rd_ptr;
        state_nxt    = state;
        overflow_nxt = 1'b0;
        wr_en        = 1'b0;
        commit       = 1'b0;
        release_pkt  = 1'b0;

        // Use the registered flags, so space freed by a pop this cycle
        // becomes usable only on the next cycle.
        push_ok     = i_push && !o_full;
        pop_ok      = i_pop && !o_empty;
        in_progress = (wr_ptr != cmt_ptr);

        if (state == WR_OK) begin
            if (i_drop) begin
                // i_drop overrides a push in the same cycle, i_last included.
                wr_ptr_nxt = cmt_ptr;
            end else if (push_ok) begin
                wr_en      = 1'b1;
                wr_ptr_nxt = inc(wr_ptr);
                if (i_last) begin
                    cmt_ptr_nxt = inc(wr_ptr);
                    commit      = 1'b1;
                end
            end else if (i_push && in_progress) begin
                // The packet cannot fit. Discard it now if this was its last
                // word; otherwise ignore writes until it ends.
                if (i_last) begin
                    wr_ptr_nxt   = cmt_ptr;
                    overflow_nxt = 1'b1;
                end else begin
                    state_nxt = WR_BAD;
                end
            end
        end else begin
            if (i_drop) begin
                wr_ptr_nxt = cmt_ptr;
                state_nxt  = WR_OK;
            end else if (i_push && i_last) begin
                wr_ptr_nxt   = cmt_ptr;
                state_nxt    = WR_OK;
                overflow_nxt = 1'b1;
            end
        end

        if (pop_ok) begin
            rd_ptr_nxt  = inc(rd_ptr);
            release_pkt = i_rd_last;
        end

        pkt_cnt_nxt = pkt_cnt + PC_W'(commit) - PC_W'(release_pkt);

        if (i_clear) begin
            wr_ptr_nxt   = '0;
            cmt_ptr_nxt  = '0;
            rd_ptr_nxt   = '0;
            state_nxt    = WR_OK;
            overflow_nxt = 1'b0;
            wr_en        = 1'b0;
            pkt_cnt_nxt  = '0;
        end

        // The flags are computed from next-state values, so the registered
        // outputs always describe the state after the edge.
        used_nxt  = ptr_distance(ptr_max_t'(wr_ptr_nxt), ptr_max_t'(rd_ptr_nxt), IDX_W, DEPTH);
        words_nxt = ptr_distance(ptr_max_t'(cmt_ptr_nxt), ptr_max_t'(rd_ptr_nxt), IDX_W, DEPTH);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr        <= '0;
            cmt_ptr       <= '0;
            rd_ptr        <= '0;
            state         <= WR_OK;
            pkt_cnt       <= '0;
            o_full        <= 1'b0;
            o_almost_full <= 1'b0;
            o_overflow    <= 1'b0;
            o_empty       <= 1'b1;
            o_word_count  <= '0;
        end else begin
            wr_ptr        <= wr_ptr_nxt;
            cmt_ptr       <= cmt_ptr_nxt;
            rd_ptr        <= rd_ptr_nxt;
            state         <= state_nxt;
            pkt_cnt       <= pkt_cnt_nxt;
            o_full        <= (used_nxt >= DEPTH) || (pkt_cnt_nxt == PC_W'(MAX_PACKETS));
            o_almost_full <= (used_nxt >= THRESHOLD);
            o_overflow    <= overflow_nxt;
            o_empty       <= (pkt_cnt_nxt == '0);
            o_word_count  <= WC_W'(words_nxt);
        end
    end

    assign o_packet_count = pkt_cnt;
    assign o_wr_en        = wr_en;
    assign o_wr_idx       = wr_ptr[IDX_W-1:0];
    assign o_rd_idx       = rd_ptr[IDX_W-1:0];

endmodule

// File: rtl/std_packet_fifo.sv
// -----------------------------------------------------------------------------
// std_packet_fifo
//
// Packet-aware synchronous FIFO. Words are written speculatively and become
// visible to the reader only after the packet's last word is committed. A
// packet can be dropped while it is being written. A packet that overflows is
// discarded automatically, and o_overflow pulses.
//
// Ports:
//   i_clk, i_rst        clock; asynchronous active-low reset
//   i_clear             synchronous clear (storage contents are kept)
//   i_push, i_data, i_last, i_drop   write side
//   o_full, o_almost_full, o_overflow write-side status
//   i_pop               read request
//   o_empty, o_data, o_last          read side (first-word fall-through)
//   o_word_count        committed, unread words
//   o_packet_count      committed packets not fully read
// -----------------------------------------------------------------------------
module std_packet_fifo
    import std_packet_fifo_pkg::*;
#(
    parameter  int unsigned WIDTH       = 8,
    parameter  type         TYPE        = logic [WIDTH-1:0],
    parameter  int unsigned DEPTH       = 16,
    parameter  int unsigned MAX_PACKETS = DEPTH,
    parameter  int unsigned THRESHOLD   = DEPTH - 1,
    localparam int unsigned IDX_W       = $clog2(DEPTH),
    localparam int unsigned WC_W        = $clog2(DEPTH + 1),
    localparam int unsigned PC_W        = $clog2(MAX_PACKETS + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clear,
    input  logic            i_push,
    input  TYPE             i_data,
    input  logic            i_last,
    input  logic            i_drop,
    output logic            o_full,
    output logic            o_almost_full,
    output logic            o_overflow,
    input  logic            i_pop,
    output logic            o_empty,
    output TYPE             o_data,
    output logic            o_last,
    output logic [WC_W-1:0] o_word_count,
    output logic [PC_W-1:0] o_packet_count
);

    typedef struct packed {
        TYPE  data;
        logic last;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           rd_entry;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx, rd_idx;

    std_packet_fifo_ctrl #(
        .DEPTH       (DEPTH),
        .MAX_PACKETS (MAX_PACKETS),
        .THRESHOLD   (THRESHOLD)
    ) u_ctrl (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_clear        (i_clear),
        .i_push         (i_push),
        .i_last         (i_last),
        .i_drop         (i_drop),
        .i_pop          (i_pop),
        .i_rd_last      (rd_entry.last),
        .o_wr_en        (wr_en),
        .o_wr_idx       (wr_idx),
        .o_rd_idx       (rd_idx),
        .o_full         (o_full),
        .o_almost_full  (o_almost_full),
        .o_overflow     (o_overflow),
        .o_empty        (o_empty),
        .o_word_count   (o_word_count),
        .o_packet_count (o_packet_count)
    );

    // NOTE: the storage array is deliberately not reset. The pointers decide
    // what is visible, so resetting every entry would only cost logic.
    always_ff @(posedge i_clk) begin
        if (wr_en)
            mem[wr_idx] <= '{data: i_data, last: i_last};
    end

    assign rd_entry = mem[rd_idx];

    // Mask the read port while empty. Reset and clear then show zeros even
    // though stale words remain in storage.
    assign o_data = o_empty ? TYPE'(0) : rd_entry.data;
    assign o_last = !o_empty && rd_entry.last;

endmodule

// File: tb/tb_std_packet_fifo.sv
// -----------------------------------------------------------------------------
// tb_std_packet_fifo
//
// Two instances run side by side:
//   u_a: DEPTH=4 (MAX_PACKETS=4, THRESHOLD=3) for basic, drop, overflow,
//        wrap and clear cases.
//   u_b: DEPTH=8, MAX_PACKETS=2 for packet-limited full and commit-with-pop.
// Stimulus pushes the expected read words into a queue per instance. A monitor
// on the falling edge pops and compares whenever a pop of a non-empty FIFO is
// about to happen.
// -----------------------------------------------------------------------------
module tb_std_packet_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance A signals
    logic       a_clear, a_push, a_last, a_drop, a_pop;
    logic [7:0] a_data, a_odata;
    logic       a_full, a_af, a_ovf, a_empty, a_olast;
    logic [2:0] a_wc, a_pc;

    // Instance B signals
    logic       b_clear, b_push, b_last, b_drop, b_pop;
    logic [7:0] b_data, b_odata;
    logic       b_full, b_af, b_ovf, b_empty, b_olast;
    logic [3:0] b_wc;
    logic [1:0] b_pc;

    std_packet_fifo #(.WIDTH(8), .DEPTH(4)) u_a (
        .i_clk(clk), .i_rst(rst), .i_clear(a_clear),
        .i_push(a_push), .i_data(a_data), .i_last(a_last), .i_drop(a_drop),
        .o_full(a_full), .o_almost_full(a_af), .o_overflow(a_ovf),
        .i_pop(a_pop), .o_empty(a_empty), .o_data(a_odata), .o_last(a_olast),
        .o_word_count(a_wc), .o_packet_count(a_pc)
    );

    std_packet_fifo #(.WIDTH(8), .DEPTH(8), .MAX_PACKETS(2)) u_b (
        .i_clk(clk), .i_rst(rst), .i_clear(b_clear),
        .i_push(b_push), .i_data(b_data), .i_last(b_last), .i_drop(b_drop),
        .o_full(b_full), .o_almost_full(b_af), .o_overflow(b_ovf),
        .i_pop(b_pop), .o_empty(b_empty), .o_data(b_odata), .o_last(b_olast),
        .o_word_count(b_wc), .o_packet_count(b_pc)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t a_q[$];
    exp_t b_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: compare the word about to be popped on the next edge.
    always @(negedge clk) begin
        if (rst && a_pop && !a_empty) begin
            if (a_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_pop_unexpected: got 0x%0h expected no word", a_odata);
            end else begin
                exp_t e;
                e = a_q.pop_front();
                check("a_pop_data", 32'(a_odata), 32'(e.data));
                check("a_pop_last", 32'(a_olast), 32'(e.last));
            end
        end
    end

    always @(negedge clk) begin
        if (rst && b_pop && !b_empty) begin
            if (b_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_pop_unexpected: got 0x%0h expected no word", b_odata);
            end else begin
                exp_t e;
                e = b_q.pop_front();
                check("b_pop_data", 32'(b_odata), 32'(e.data));
                check("b_pop_last", 32'(b_olast), 32'(e.last));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        a_clear = 0; a_push = 0; a_last = 0; a_drop = 0; a_pop = 0; a_data = '0;
        b_clear = 0; b_push = 0; b_last = 0; b_drop = 0; b_pop = 0; b_data = '0;
    endtask

    // One push cycle. exp_out marks words the reader is expected to see.
    task automatic a_send(input logic [7:0] d, input logic l, input bit exp_out);
        exp_t e;
        a_push = 1; a_data = d; a_last = l;
        if (exp_out) begin
            e.data = d; e.last = l;
            a_q.push_back(e);
        end
        step();
        a_push = 0; a_last = 0;
    endtask

    task automatic b_send(input logic [7:0] d, input logic l, input bit exp_out);
        exp_t e;
        b_push = 1; b_data = d; b_last = l;
        if (exp_out) begin
            e.data = d; e.last = l;
            b_q.push_back(e);
        end
        step();
        b_push = 0; b_last = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst = 0;
        idle_all();
        repeat (3) step();

        // Reset values
        check("rst_empty",    32'(a_empty), 32'(1));
        check("rst_full",     32'(a_full),  32'(0));
        check("rst_afull",    32'(a_af),    32'(0));
        check("rst_overflow", 32'(a_ovf),   32'(0));
        check("rst_wc",       32'(a_wc),    32'(0));
        check("rst_pc",       32'(a_pc),    32'(0));
        check("rst_data",     32'(a_odata), 32'(0));
        check("rst_last",     32'(a_olast), 32'(0));
        check("rst_b_empty",  32'(b_empty), 32'(1));
        rst = 1;
        step();

        // 3-word packet: invisible until the commit
        a_send(8'hA1, 0, 1);
        check("t1_empty_w1", 32'(a_empty), 32'(1));
        a_send(8'hA2, 0, 1);
        check("t1_empty_w2", 32'(a_empty), 32'(1));
        check("t1_afull_w2", 32'(a_af),    32'(0));
        a_send(8'hA3, 1, 1);
        check("t1_empty_cmt", 32'(a_empty), 32'(0));
        check("t1_wc",        32'(a_wc),    32'(3));
        check("t1_pc",        32'(a_pc),    32'(1));
        check("t1_afull_w3",  32'(a_af),    32'(1));
        a_pop = 1;
        repeat (3) step();
        a_pop = 0;
        check("t1_empty_done", 32'(a_empty), 32'(1));
        check("t1_wc_done",    32'(a_wc),    32'(0));
        check("t1_pc_done",    32'(a_pc),    32'(0));

        // Drop a 2-word packet, then a 1-word packet
        a_send(8'h11, 0, 0);
        a_send(8'h12, 0, 0);
        a_drop = 1;
        step();
        a_drop = 0;
        check("t2_empty", 32'(a_empty), 32'(1));
        check("t2_full",  32'(a_full),  32'(0));
        check("t2_wc",    32'(a_wc),    32'(0));
        check("t2_pc",    32'(a_pc),    32'(0));
        a_send(8'h55, 1, 1);
        check("t2_empty_55", 32'(a_empty), 32'(0));
        check("t2_wc_55",    32'(a_wc),    32'(1));
        a_pop = 1;
        step();
        a_pop = 0;
        check("t2_empty_done", 32'(a_empty), 32'(1));

        // Overflow: a 6-word packet into 4 slots
        for (int i = 0; i < 6; i++) begin
            a_send(8'(8'h61 + i), (i == 5), 0);
            if (i == 2) begin
                check("t3_full_w3",  32'(a_full), 32'(0));
                check("t3_afull_w3", 32'(a_af),   32'(1));
            end
            if (i == 3)
                check("t3_full_w4", 32'(a_full), 32'(1));
            if (i == 4) begin
                check("t3_full_w5", 32'(a_full), 32'(1));
                check("t3_ovf_w5",  32'(a_ovf),  32'(0));
            end
        end
        check("t3_ovf",   32'(a_ovf),   32'(1));
        check("t3_empty", 32'(a_empty), 32'(1));
        check("t3_wc",    32'(a_wc),    32'(0));
        check("t3_pc",    32'(a_pc),    32'(0));
        check("t3_full",  32'(a_full),  32'(0));
        step();
        check("t3_ovf_pulse_end", 32'(a_ovf), 32'(0));

        // Wrap: 5 one-word packets through 4 slots
        for (int i = 1; i <= 5; i++) begin
            a_send(8'(i), 1, 1);
            check("t4_wc", 32'(a_wc), 32'(1));
            a_pop = 1;
            step();
            a_pop = 0;
        end
        check("t4_empty", 32'(a_empty), 32'(1));

        // Clear mid-packet with 2 packets committed
        a_send(8'h71, 1, 0);
        a_send(8'h72, 1, 0);
        check("t5_pc", 32'(a_pc), 32'(2));
        check("t5_wc", 32'(a_wc), 32'(2));
        a_send(8'h73, 0, 0);
        check("t5_afull", 32'(a_af), 32'(1));
        a_clear = 1;
        step();
        a_clear = 0;
        check("t5_clr_empty", 32'(a_empty), 32'(1));
        check("t5_clr_full",  32'(a_full),  32'(0));
        check("t5_clr_afull", 32'(a_af),    32'(0));
        check("t5_clr_ovf",   32'(a_ovf),   32'(0));
        check("t5_clr_wc",    32'(a_wc),    32'(0));
        check("t5_clr_pc",    32'(a_pc),    32'(0));
        check("t5_clr_data",  32'(a_odata), 32'(0));
        check("t5_clr_last",  32'(a_olast), 32'(0));

        // Packet-limited full on B
        b_send(8'h81, 1, 1);
        b_send(8'h82, 1, 1);
        check("t6_full", 32'(b_full), 32'(1));
        check("t6_pc",   32'(b_pc),   32'(2));
        check("t6_wc",   32'(b_wc),   32'(2));
        check("t6_af",   32'(b_af),   32'(0));
        b_send(8'h83, 1, 0);
        check("t6_ign_pc",   32'(b_pc),   32'(2));
        check("t6_ign_wc",   32'(b_wc),   32'(2));
        check("t6_ign_ovf",  32'(b_ovf),  32'(0));
        check("t6_ign_full", 32'(b_full), 32'(1));
        b_pop = 1;
        step();
        b_pop = 0;
        check("t6_full_after_pop", 32'(b_full), 32'(0));
        check("t6_pc_after_pop",   32'(b_pc),   32'(1));

        // Commit and pop of the last committed word in the same cycle
        b_push = 1; b_data = 8'h84; b_last = 1; b_pop = 1;
        e.data = 8'h84; e.last = 1'b1;
        b_q.push_back(e);
        step();
        b_push = 0; b_last = 0; b_pop = 0;
        check("t7_pc",    32'(b_pc),    32'(1));
        check("t7_empty", 32'(b_empty), 32'(0));
        check("t7_wc",    32'(b_wc),    32'(1));
        b_pop = 1;
        step();
        b_pop = 0;
        check("t7_empty_done", 32'(b_empty), 32'(1));
        check("t7_pc_done",    32'(b_pc),    32'(0));

        // Asynchronous reset in mid-packet, between clock edges
        b_send(8'h92, 1, 0);
        b_send(8'h93, 0, 0);
        a_send(8'h9A, 1, 0);
        check("t8_b_empty_pre", 32'(b_empty), 32'(0));
        check("t8_a_empty_pre", 32'(a_empty), 32'(0));
        #2;
        rst = 0;
        #1;
        check("t8_b_empty", 32'(b_empty), 32'(1));
        check("t8_b_pc",    32'(b_pc),    32'(0));
        check("t8_b_wc",    32'(b_wc),    32'(0));
        check("t8_a_empty", 32'(a_empty), 32'(1));
        check("t8_a_wc",    32'(a_wc),    32'(0));
        step();
        rst = 1;
        step();

        check("a_queue_drained", 32'(a_q.size()), 32'(0));
        check("b_queue_drained", 32'(b_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
